// File: rtl/lock_pkg.sv
// Shared types for the lock-sequencer arbiter: FSM state encoding and lock progress codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lock_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Progress code returned by the shared lock sequencer
    typedef logic [1:0] lock_ca_t;
    localparam lock_ca_t LOCK_CA_DONE = 2'b11;

    // Requester index; wide enough for up to 8 requesters
    typedef logic [2:0] owner_t;

    // Grant timer width: ceil(log2(timeout)), never less than one bit
    function automatic int timer_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/lock_share_arbiter_if.sv
// Requester/lock-sequencer bundle for lock_share_arbiter.
// Latency: n/a (wires only).
// Backpressure: n/a; req is a level, strobes are single-cycle.
// Ports: req/c1_in/c2_in from requesters, lock_ca from the sequencer;
//        gnt/owner/done/timeout back to requesters, lock_* to the sequencer.
interface lock_share_arbiter_if #(
    parameter int N_REQ = 4
);
    import lock_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] c1_in;
    logic [N_REQ-1:0] c2_in;
    logic [N_REQ-1:0] gnt;
    owner_t           owner;
    logic             lock_rst;
    logic             lock_c1;
    logic             lock_c2;
    logic             lock_i;
    lock_ca_t         lock_ca;
    logic             done;
    logic             timeout;

    // Arbiter side
    modport slave (
        input  req, c1_in, c2_in, lock_ca,
        output gnt, owner, lock_rst, lock_c1, lock_c2, lock_i, done, timeout
    );

    // Requester / sequencer side
    modport master (
        output req, c1_in, c2_in, lock_ca,
        input  gnt, owner, lock_rst, lock_c1, lock_c2, lock_i, done, timeout
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin winner pick: first set req bit at or after pointer rr, wrapping modulo N_REQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; vld is low when no request is pending.
// Ports: req (request vector), rr (start pointer) -> vld (any request), idx (winner).
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       rr,
    output logic             vld,
    output logic [2:0]       idx
);

    // Zero-extended so a 3-bit index is always in range regardless of N_REQ
    logic [7:0] req_ext;
    assign req_ext = 8'(req);

    always_comb begin
        vld = 1'b0;
        idx = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!vld && req_ext[3'((int'(rr) + i) % N_REQ)]) begin
                vld = 1'b1;
                idx = 3'((int'(rr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/lock_share_arbiter.sv
// Arbitrates N_REQ requesters onto one shared lock sequencer; round-robin, one owner at a time.
// Latency: grant one cycle after request (CLEAR), key strobes pass through combinationally in GRANT.
// Backpressure: non-owners wait with req held; grant ends on done, owner abort, or TIMEOUT expiry.
// Ports: clk, reset (sync, active-high); bus = lock_share_arbiter_if.slave (requester + sequencer signals).
module lock_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    lock_share_arbiter_if.slave  bus
);
    import lock_pkg::*;

    localparam int           TW       = timer_width(TIMEOUT);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam owner_t       LAST_IDX = 3'(N_REQ - 1);

    state_t          state_q;
    state_t          state_d;
    owner_t          rr_q;
    owner_t          owner_q;
    logic [TW-1:0]   timer_q;

    logic            pick_vld;
    owner_t          pick_idx;

    logic [7:0]      req_ext;
    logic [7:0]      c1_ext;
    logic [7:0]      c2_ext;

    logic [N_REQ-1:0] gnt_c;
    logic            lock_rst_c;
    logic            lock_i_c;
    logic            lock_c1_c;
    logic            lock_c2_c;
    logic            done_c;
    logic            timeout_c;

    // Widened copies so owner_q can index them for any legal N_REQ
    assign req_ext = 8'(bus.req);
    assign c1_ext  = 8'(bus.c1_in);
    assign c2_ext  = 8'(bus.c2_in);

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req (bus.req),
        .rr  (rr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q    <= 3'd0;
            owner_q <= 3'd0;
            timer_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE:    if (pick_vld) owner_q <= pick_idx;
                ST_CLEAR:   timer_q <= '0;
                // Saturate so a stuck GRANT can never wrap back under the limit
                ST_GRANT:   if (timer_q != '1) timer_q <= timer_q + TW'(1);
                ST_RELEASE: rr_q <= (owner_q == LAST_IDX) ? 3'd0 : owner_q + 3'd1;
                default:    ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_c      = '0;
        lock_rst_c = 1'b0;
        lock_i_c   = 1'b0;
        lock_c1_c  = 1'b0;
        lock_c2_c  = 1'b0;
        done_c     = 1'b0;
        timeout_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                gnt_c      = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
                lock_rst_c = 1'b1;
                state_d    = ST_GRANT;
            end
            ST_GRANT: begin
                gnt_c     = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
                lock_i_c  = 1'b1;
                lock_c1_c = c1_ext[owner_q];
                lock_c2_c = c2_ext[owner_q];
                // Priority: completion beats abort beats expiry, so at most one pulse fires
                if (bus.lock_ca == LOCK_CA_DONE) begin
                    done_c  = 1'b1;
                    state_d = ST_RELEASE;
                end else if (!req_ext[owner_q]) begin
                    state_d = ST_RELEASE;
                end else if (timer_q == T_LAST) begin
                    timeout_c = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                lock_rst_c = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset masks the grant-side outputs at once and holds the sequencer in reset with us
    assign bus.gnt      = reset ? '0 : gnt_c;
    assign bus.owner    = owner_q;
    assign bus.lock_rst = reset | lock_rst_c;
    assign bus.lock_i   = ~reset & lock_i_c;
    assign bus.lock_c1  = ~reset & lock_c1_c;
    assign bus.lock_c2  = ~reset & lock_c2_c;
    assign bus.done     = ~reset & done_c;
    assign bus.timeout  = ~reset & timeout_c;

endmodule

// File: tb/tb_lock_share_arbiter.sv
// Bench for lock_share_arbiter: table vectors, directed corner sequences, and random traffic vs. a reference model.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the following falling edge.
// Backpressure: n/a.
module tb_lock_share_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lock_share_arbiter_if #(.N_REQ(N)) bus ();

    lock_share_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0=idle 1=clear 2=grant 3=release; m_gcnt = grant cycles already spent
    int m_phase = 0;
    int m_owner = 0;
    int m_rr    = 0;
    int m_gcnt  = 0;

    // Last sampled DUT outputs
    logic [3:0] s_gnt;
    logic       s_lr, s_li, s_c1, s_c2, s_done, s_to;

    typedef struct {
        logic       r;
        logic [3:0] rq, c1, c2;
        logic [1:0] ca;
        logic [3:0] gnt;
        logic       lr, li, o1, o2, d, t;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] model_out(input logic r, input logic [3:0] rq,
                                              input logic [3:0] c1, input logic [3:0] c2,
                                              input logic [1:0] ca);
        logic [3:0] g  = 4'b0000;
        logic [2:0] ow = 3'd0;
        logic lr = 1'b0, li = 1'b0, o1 = 1'b0, o2 = 1'b0, d = 1'b0, t = 1'b0;
        if (r) begin
            lr = 1'b1;
        end else if (m_phase == 1) begin
            g  = 4'b0001 << m_owner;
            lr = 1'b1;
        end else if (m_phase == 2) begin
            g  = 4'b0001 << m_owner;
            li = 1'b1;
            o1 = c1[2'(m_owner)];
            o2 = c2[2'(m_owner)];
            d  = (ca == 2'b11);
            t  = !d && rq[2'(m_owner)] && (m_gcnt == TO - 1);
        end else if (m_phase == 3) begin
            lr = 1'b1;
        end
        if (g != 4'b0000) ow = 3'(m_owner);
        return {g, ow, lr, li, o1, o2, d, t};
    endfunction

    task automatic model_step(input logic r, input logic [3:0] rq, input logic [1:0] ca);
        bit found = 0;
        if (r) begin
            m_phase = 0; m_rr = 0; m_owner = 0; m_gcnt = 0;
        end else begin
            case (m_phase)
                0: if (rq != 4'b0000) begin
                       for (int i = 0; i < N; i++) begin
                           int c = (m_rr + i) % N;
                           if (!found && rq[2'(c)]) begin
                               found = 1; m_owner = c;
                           end
                       end
                       m_phase = 1;
                   end
                1: begin m_gcnt = 0; m_phase = 2; end
                2: begin
                       if (ca == 2'b11 || !rq[2'(m_owner)] || m_gcnt == TO - 1) m_phase = 3;
                       m_gcnt++;
                   end
                default: begin m_rr = (m_owner + 1) % N; m_phase = 0; end
            endcase
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, compare against model, advance model, cross the edge
    task automatic cycle(input logic r, input logic [3:0] rq, input logic [3:0] c1,
                         input logic [3:0] c2, input logic [1:0] ca);
        logic [13:0] exp, act;
        reset       = r;
        bus.req     = rq;
        bus.c1_in   = c1;
        bus.c2_in   = c2;
        bus.lock_ca = ca;
        #4;
        s_gnt = bus.gnt; s_lr = bus.lock_rst; s_li = bus.lock_i;
        s_c1 = bus.lock_c1; s_c2 = bus.lock_c2; s_done = bus.done; s_to = bus.timeout;
        act = {s_gnt, (s_gnt != 4'b0000) ? bus.owner : 3'd0, s_lr, s_li, s_c1, s_c2, s_done, s_to};
        exp = model_out(r, rq, c1, c2, ca);
        check("model", 32'(act), 32'(exp));
        model_step(r, rq, ca);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] rq;
        int gc, to_at, to_n;
        bit got;

        reset = 1'b1; bus.req = '0; bus.c1_in = '0; bus.c2_in = '0; bus.lock_ca = 2'b00;
        @(posedge clk);
        #1;

        // Single requester walk-through: strobes only from owner 1 reach the sequencer
        tbl[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 2'b00, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 2'b00, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 2'b00, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 4'b0010, 4'b0001, 4'b1000, 2'b00, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 2'b11, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 2'b11, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 9; k++) begin
            cycle(tbl[k].r, tbl[k].rq, tbl[k].c1, tbl[k].c2, tbl[k].ca);
            check($sformatf("vec%0d", k), 32'({s_gnt, s_lr, s_li, s_c1, s_c2, s_done, s_to}),
                  32'({tbl[k].gnt, tbl[k].lr, tbl[k].li, tbl[k].o1, tbl[k].o2, tbl[k].d, tbl[k].t}));
        end

        // Fairness: all four requesting continuously, each grant closed by done after two GRANT cycles
        cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int w = 0; w < 10 && !got; w++) begin
                cycle(1'b0, 4'b1111, 4'b0000, 4'b0000, 2'b00);
                if (s_gnt != 4'b0000) got = 1;
            end
            check("fair_order", 32'(s_gnt), 32'(4'b0001 << k));
            cycle(1'b0, 4'b1111, 4'b0000, 4'b0000, 2'b00);
            cycle(1'b0, 4'b1111, 4'b0000, 4'b0000, 2'b00);
            cycle(1'b0, 4'b1111, 4'b0000, 4'b0000, 2'b11);
            check("fair_done", 32'(s_done), 32'd1);
        end

        // Timeout: owner 2, lock never completes
        cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        gc = 0; to_at = -1; to_n = 0;
        for (int c = 0; c < 30 && to_n == 0; c++) begin
            cycle(1'b0, 4'b0100, 4'b0000, 4'b0000, 2'b00);
            if (s_li) gc++;
            if (s_to) begin to_n++; to_at = gc; end
        end
        check("to_cycle", 32'(to_at), 32'd16);
        cycle(1'b0, 4'b0100, 4'b0000, 4'b0000, 2'b00);
        check("to_release", 32'({s_gnt, s_lr, s_to}), 32'({4'b0000, 1'b1, 1'b0}));

        // Abort: owner 0 drops req in GRANT cycle 3
        cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        cycle(1'b0, 4'b0001, 4'b0000, 4'b0000, 2'b00);
        cycle(1'b0, 4'b0001, 4'b0000, 4'b0000, 2'b00);
        cycle(1'b0, 4'b0001, 4'b0000, 4'b0000, 2'b00);
        cycle(1'b0, 4'b0001, 4'b0000, 4'b0000, 2'b00);
        cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        check("abort_g3", 32'({s_li, s_done, s_to}), 32'({1'b1, 1'b0, 1'b0}));
        cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        check("abort_release", 32'({s_gnt, s_lr, s_done, s_to}), 32'({4'b0000, 1'b1, 1'b0, 1'b0}));

        // Collision: done, abort and expiry all in GRANT cycle 16 -> done only
        cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        for (int c = 0; c < 17; c++) cycle(1'b0, 4'b0001, 4'b0000, 4'b0000, 2'b00);
        cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b11);
        check("collide", 32'({s_li, s_done, s_to}), 32'({1'b1, 1'b1, 1'b0}));
        cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        check("collide_release", 32'({s_gnt, s_lr}), 32'({4'b0000, 1'b1}));

        // Reset mid-grant: owner 1 would have moved rr to 2; after reset owner 0 must win
        cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        cycle(1'b0, 4'b0010, 4'b0000, 4'b0000, 2'b00);
        cycle(1'b0, 4'b0010, 4'b0000, 4'b0000, 2'b00);
        cycle(1'b0, 4'b0010, 4'b0000, 4'b0000, 2'b00);
        cycle(1'b0, 4'b0010, 4'b0000, 4'b0000, 2'b00);
        cycle(1'b1, 4'b0010, 4'b0010, 4'b0010, 2'b11);
        check("rst_mid", 32'({s_gnt, s_lr, s_li, s_c1, s_c2, s_done, s_to}),
              32'({4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        cycle(1'b0, 4'b1111, 4'b0000, 4'b0000, 2'b00);
        check("rst_after", 32'({s_gnt, s_lr, s_li, s_done, s_to}),
              32'({4'b0000, 1'b0, 1'b0, 1'b0, 1'b0}));
        cycle(1'b0, 4'b1111, 4'b0000, 4'b0000, 2'b00);
        check("rst_rr", 32'(s_gnt), 32'(4'b0001));

        // Random traffic against the model
        cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        rq = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            int b;
            logic [1:0] ca;
            b = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            ca = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            cycle(($urandom_range(0, 149) == 0), rq, 4'($urandom), 4'($urandom), ca);
            check("pulse_excl", 32'(s_done & s_to), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lock_share_arbiter.md
LOCK_SHARE_ARBITER -- requirements
Module: lock_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the lock sequencer; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles a grant is held in GRANT; legal range 2..255.
REQ-003 clk  input  1  single clock, all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 req  input  N_REQ  per-requester access request, level.
REQ-006 c1_in  input  N_REQ  per-requester key-1 strobe.
REQ-007 c2_in  input  N_REQ  per-requester key-2 strobe.
REQ-008 gnt  output  N_REQ  one-hot grant, all zero when no owner.
REQ-009 owner  output  3  index of the current owner, valid only while gnt is non-zero.
REQ-010 lock_rst  output  1  reset to the shared lock sequencer, active-high.
REQ-011 lock_c1, lock_c2, lock_i  output  1 each  key strobes and enable driven to the shared lock sequencer.
REQ-012 lock_ca  input  2  progress code returned by the lock sequencer; 2'b11 means the sequence completed.
REQ-013 done, timeout  output  1 each  single-cycle completion and expiry pulses.

Function
REQ-014 The FSM SHALL have the states IDLE, CLEAR, GRANT and RELEASE.
REQ-015 IDLE: if any req bit is high, the winner SHALL be chosen round-robin starting at pointer rr, owner SHALL be registered, and the next state SHALL be CLEAR; otherwise the FSM SHALL remain in IDLE.
REQ-016 CLEAR: lock_rst=1 and gnt=one-hot(owner) SHALL hold for exactly one cycle, the timer SHALL be cleared, and the next state SHALL be GRANT.
REQ-017 GRANT: gnt=one-hot(owner), lock_i=1, lock_c1=c1_in[owner] and lock_c2=c2_in[owner] SHALL be driven combinationally with zero latency; strobes from non-owners SHALL be ignored.
REQ-018 GRANT exits SHALL be evaluated in priority order: (1) lock_ca==2'b11 -> done=1; (2) req[owner]==0 -> abort with no pulse; (3) timer==TIMEOUT-1 -> timeout=1. Every exit SHALL go to RELEASE.
REQ-019 The timer SHALL increment by one each GRANT cycle and SHALL saturate without wrapping; it SHALL be ceil(log2(TIMEOUT)) bits wide, with a minimum of 1 bit.
REQ-020 RELEASE: lock_rst=1 and gnt=0 for one cycle, rr SHALL become (owner+1) mod N_REQ, and the next state SHALL be IDLE.
REQ-021 Outside GRANT, lock_c1, lock_c2 and lock_i SHALL be 0.
REQ-022 Outside CLEAR and RELEASE, lock_rst SHALL be 0.
REQ-023 Minimum turnaround between grants SHALL be 2 cycles (RELEASE, IDLE); no requester SHALL be granted twice while another requester has held req high across the previous RELEASE.
REQ-024 A req raised or dropped by a non-owner during CLEAR, GRANT or RELEASE SHALL NOT affect the current grant.
REQ-025 done and timeout SHALL never be high in the same cycle.

Reset
REQ-026 When reset=1 at a clock edge, the FSM SHALL enter IDLE and rr, owner and timer SHALL be cleared to 0.
REQ-027 During reset and in the first cycle after it, the outputs SHALL be gnt=0, done=0, timeout=0, lock_c1=0, lock_c2=0 and lock_i=0.
REQ-028 lock_rst SHALL be 1 while reset=1, so that the shared sequencer is cleared alongside the arbiter.
REQ-029 A reset in the middle of a grant SHALL drop gnt on the next edge and SHALL NOT produce a done or timeout pulse.

Structure
REQ-030 The state encodings and the lock_ca completion code 2'b11 SHALL be defined in the shared package lock_pkg.
REQ-031 The round-robin winner selection SHALL be a sub-module, rr_pick, that is purely combinational with inputs req and rr and outputs a valid flag and the winner index.

Verification
REQ-032 Single requester: req=4'b0010, then c1_in[1] and c2_in[1] pulses, and lock_ca=11 in the fourth GRANT cycle -> gnt=0010 from CLEAR onward, done pulses once, then gnt=0000 in RELEASE.
REQ-033 Fairness: req=4'b1111 held through four grants, each completed by done -> grant order 0,1,2,3.
REQ-034 Timeout: owner 2 granted and lock_ca held at 00 -> timeout pulses in GRANT cycle 16 (TIMEOUT=16), followed by RELEASE with lock_rst=1.
REQ-035 Abort: owner drops req in GRANT cycle 3 -> RELEASE on the next edge with no done and no timeout pulse.
REQ-036 Collision: lock_ca=11, req[owner]=0 and timer==TIMEOUT-1 in the same cycle -> only done pulses.
REQ-037 Reset during GRANT: reset=1 for one cycle -> gnt=0, lock_rst=1, rr=0, with no pulses.
